// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the RV32 pipeline control blocks: scheduler state encoding and
// default limits for the multi-cycle timeout counter.
package rv_pipe_pkg;

  localparam logic [1:0] SCHED_RUN      = 2'd0;
  localparam logic [1:0] SCHED_MC_BUSY  = 2'd1;
  localparam logic [1:0] SCHED_MEM_WAIT = 2'd2;
  localparam logic [1:0] SCHED_MC_MEM   = 2'd3;

  localparam int unsigned MC_MAX_CYCLES = 64;
  localparam int unsigned CNT_W         = 16;

  typedef enum logic [1:0] {
    StRun     = SCHED_RUN,
    StMcBusy  = SCHED_MC_BUSY,
    StMemWait = SCHED_MEM_WAIT,
    StMcMem   = SCHED_MC_MEM
  } sched_state_e;

endpackage

// File: rtl/stall_cycle_counter.sv
// Cycle counter with synchronous clear and enable; saturates or wraps, and flags when the
// count equals Limit.
module stall_cycle_counter #(
  parameter int unsigned Width    = 16,
  parameter int unsigned Limit    = 63,
  parameter bit          Saturate = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o,
  output logic             at_limit_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (!(Saturate && (&cnt_q))) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign at_limit_o = (cnt_q == Width'(Limit));

endmodule

// File: rtl/pipeline_stall_scheduler.sv
// Fixed-priority stall/flush sequencer for the 5-stage RV32 pipeline.
// Define STALL_PERF_CNT_EN to add the stall-cycle and flush performance counters.
module pipeline_stall_scheduler
  import rv_pipe_pkg::*;
#(
  parameter int unsigned McMaxCycles = MC_MAX_CYCLES,
  parameter int unsigned CntW        = CNT_W
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            hz_stall_i,
  input  logic            hz_redirect_i,
  input  logic            mc_start_i,
  input  logic            mc_done_i,
  input  logic            imem_busy_i,
  input  logic            dmem_busy_i,
  output logic            pc_we_o,
  output logic            if_id_we_o,
  output logic            if_id_flush_o,
  output logic            id_ex_we_o,
  output logic            id_ex_bubble_o,
  output logic            ex_mem_we_o,
  output logic            ex_mem_bubble_o,
  output logic            mem_wb_we_o,
  output logic [1:0]      sched_state_o,
  output logic            mc_timeout_o
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [CntW-1:0] perf_stall_cyc_o,
  output logic [CntW-1:0] perf_flush_cnt_o
`endif
);

  sched_state_e state_q, state_d;
  logic         kill_pend_q, kill_pend_d;
  logic         mc_timeout_q, mc_timeout_d;
  logic         mc_active, mc_hold, mc_enter, redirect_taken, at_limit;
  logic [CntW-1:0] mc_cnt_unused;

  // MC_MEM is still a multi-cycle episode: EX stays held once the memory freeze lifts.
  assign mc_active = (state_q == StMcBusy) || (state_q == StMcMem);
  assign mc_hold   = mc_active && !mc_done_i;
  assign mc_enter  = (state_q == StRun) && mc_start_i && !mc_done_i;
  assign redirect_taken = hz_redirect_i && !dmem_busy_i && !mc_hold && !hz_stall_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun: begin
        if (mc_enter) begin
          state_d = StMcBusy;
        end else if (dmem_busy_i) begin
          state_d = StMemWait;
        end
      end
      StMcBusy: begin
        if (mc_done_i) begin
          state_d = StRun;
        end else if (dmem_busy_i) begin
          state_d = StMcMem;
        end
      end
      StMemWait: if (!dmem_busy_i) state_d = StRun;
      StMcMem:   if (!dmem_busy_i) state_d = StMcBusy;
      default:   state_d = StRun;
    endcase
  end

  always_comb begin
    pc_we_o         = 1'b1;
    if_id_we_o      = 1'b1;
    if_id_flush_o   = 1'b0;
    id_ex_we_o      = 1'b1;
    id_ex_bubble_o  = 1'b0;
    ex_mem_we_o     = 1'b1;
    ex_mem_bubble_o = 1'b0;
    mem_wb_we_o     = 1'b1;
    if (dmem_busy_i) begin
      pc_we_o     = 1'b0;
      if_id_we_o  = 1'b0;
      id_ex_we_o  = 1'b0;
      ex_mem_we_o = 1'b0;
      mem_wb_we_o = 1'b0;
    end else if (mc_hold) begin
      pc_we_o         = 1'b0;
      if_id_we_o      = 1'b0;
      id_ex_we_o      = 1'b0;
      ex_mem_bubble_o = 1'b1;
    end else if (hz_stall_i) begin
      pc_we_o        = 1'b0;
      if_id_we_o     = 1'b0;
      id_ex_bubble_o = 1'b1;
    end else if (hz_redirect_i) begin
      pc_we_o       = 1'b1;
      if_id_flush_o = 1'b1;
    end else if (imem_busy_i) begin
      pc_we_o       = 1'b0;
      if_id_flush_o = 1'b1;
    end
    // The wrong-path fetch still in flight must never reach ID.
    if (kill_pend_q && !dmem_busy_i) begin
      if_id_flush_o = 1'b1;
    end
  end

  always_comb begin
    kill_pend_d = kill_pend_q;
    if (!dmem_busy_i && !imem_busy_i) begin
      kill_pend_d = 1'b0;
    end
    if (redirect_taken && imem_busy_i) begin
      kill_pend_d = 1'b1;
    end
  end

  stall_cycle_counter #(
    .Width    (CntW),
    .Limit    (McMaxCycles - 1),
    .Saturate (1'b1)
  ) u_mc_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (mc_enter),
    .en_i       (mc_active),
    .cnt_o      (mc_cnt_unused),
    .at_limit_o (at_limit)
  );

  assign mc_timeout_d = mc_timeout_q | (mc_active && at_limit && !mc_done_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StRun;
      kill_pend_q  <= 1'b0;
      mc_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      kill_pend_q  <= kill_pend_d;
      mc_timeout_q <= mc_timeout_d;
    end
  end

  assign sched_state_o = state_q;
  assign mc_timeout_o  = mc_timeout_q;

`ifdef STALL_PERF_CNT_EN
  logic perf_stall_unused, perf_flush_unused;

  stall_cycle_counter #(
    .Width    (CntW),
    .Limit    (0),
    .Saturate (1'b0)
  ) u_perf_stall (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (1'b0),
    .en_i       (!pc_we_o),
    .cnt_o      (perf_stall_cyc_o),
    .at_limit_o (perf_stall_unused)
  );

  stall_cycle_counter #(
    .Width    (CntW),
    .Limit    (0),
    .Saturate (1'b0)
  ) u_perf_flush (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (1'b0),
    .en_i       (if_id_flush_o),
    .cnt_o      (perf_flush_cnt_o),
    .at_limit_o (perf_flush_unused)
  );
`endif

endmodule
